matrix_mult_engine: RTL and testbench

Sequential matrix-multiply engine computing C = A x B for AROW x ACOL by ACOL x BCOL integer matrices held in external single-cycle-read memories. It uses one multiply-accumulate datapath, walks the output elements in row-major order and writes each result to a C memory port. A Start/Busy/Done handshake lets a controller launch one full multiply per Start.

---
 rtl/matrix_mult_engine.sv | 232 +++++++++++++++++++++++
 tb/tb_matrix_mult_engine.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_mult_engine.sv
`default_nettype none
// ============================================================================
// Module      : matrix_mult_engine
// Description : Sequential C = A x B engine with one MAC, row-major C writes.
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_mult_engine #(
  parameter int AROW         = 2,
  parameter int ACOL         = 2,
  parameter int BCOL         = 2,
  parameter int A_DATA_WIDTH = 8,
  parameter int B_DATA_WIDTH = 8,
  parameter int SIGNED       = 0,
  localparam int C_DATA_WIDTH = A_DATA_WIDTH + B_DATA_WIDTH + clogb2(ACOL),
  localparam int A_AW = (clogb2(AROW*ACOL) > 1) ? clogb2(AROW*ACOL) : 1,
  localparam int B_AW = (clogb2(ACOL*BCOL) > 1) ? clogb2(ACOL*BCOL) : 1,
  localparam int C_AW = (clogb2(AROW*BCOL) > 1) ? clogb2(AROW*BCOL) : 1
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    Start,
  output logic                    Busy,
  output logic                    Done,
  output logic                    A_re,
  output logic [A_AW-1:0]         A_addr,
  input  logic [A_DATA_WIDTH-1:0] A_data,
  output logic                    B_re,
  output logic [B_AW-1:0]         B_addr,
  input  logic [B_DATA_WIDTH-1:0] B_data,
  output logic                    C_we,
  output logic [C_AW-1:0]         C_addr,
  output logic [C_DATA_WIDTH-1:0] C_data
);

  function automatic int clogb2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

  localparam int c_PW = A_DATA_WIDTH + B_DATA_WIDTH;
  localparam int c_IW = (clogb2(AROW) > 1) ? clogb2(AROW) : 1;
  localparam int c_JW = (clogb2(BCOL) > 1) ? clogb2(BCOL) : 1;
  localparam int c_KW = (clogb2(ACOL) > 1) ? clogb2(ACOL) : 1;
  localparam logic [c_IW-1:0] c_ILAST = c_IW'(AROW - 1);
  localparam logic [c_JW-1:0] c_JLAST = c_JW'(BCOL - 1);
  localparam logic [c_KW-1:0] c_KLAST = c_KW'(ACOL - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_DRAIN = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [c_IW-1:0]   r_i, w_i;
  logic [c_JW-1:0]   r_j, w_j;
  logic [c_KW-1:0]   r_k, w_k;
  logic              r_busy, w_busy;
  logic              r_done, w_done;
  logic              r_rd, w_rd;
  logic              r_we, w_we;
  logic [A_AW-1:0]   r_aaddr, w_aaddr;
  logic [B_AW-1:0]   r_baddr, w_baddr;
  logic [C_AW-1:0]   r_caddr, w_caddr;

  function automatic logic [A_AW-1:0] f_aaddr(input logic [c_IW-1:0] i, input logic [c_KW-1:0] k);
    return A_AW'(int'(i) * ACOL + int'(k));
  endfunction

  function automatic logic [B_AW-1:0] f_baddr(input logic [c_KW-1:0] k, input logic [c_JW-1:0] j);
    return B_AW'(int'(k) * BCOL + int'(j));
  endfunction

  function automatic logic [C_AW-1:0] f_caddr(input logic [c_IW-1:0] i, input logic [c_JW-1:0] j);
    return C_AW'(int'(i) * BCOL + int'(j));
  endfunction

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_i     <= '0;
      r_j     <= '0;
      r_k     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_rd    <= 1'b0;
      r_we    <= 1'b0;
      r_aaddr <= '0;
      r_baddr <= '0;
      r_caddr <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_i     <= w_i;
      r_j     <= w_j;
      r_k     <= w_k;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_rd    <= w_rd;
      r_we    <= w_we;
      r_aaddr <= w_aaddr;
      r_baddr <= w_baddr;
      r_caddr <= w_caddr;
    end
  end

  // Registered outputs are computed from the state being entered.
  always_comb begin
    w_state_nxt = r_state;
    w_i         = r_i;
    w_j         = r_j;
    w_k         = r_k;
    w_busy      = r_busy;
    w_done      = 1'b0;
    w_rd        = 1'b0;
    w_we        = 1'b0;
    w_aaddr     = r_aaddr;
    w_baddr     = r_baddr;
    w_caddr     = r_caddr;
    case (r_state)
      S_IDLE: begin
        if (Start) begin
          w_state_nxt = S_FETCH;
          w_i         = '0;
          w_j         = '0;
          w_k         = '0;
          w_busy      = 1'b1;
          w_rd        = 1'b1;
        end
      end
      S_FETCH: begin
        if (r_k == c_KLAST) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_k  = r_k + c_KW'(1);
          w_rd = 1'b1;
        end
      end
      S_DRAIN: begin
        w_state_nxt = S_WRITE;
        w_we        = 1'b1;
      end
      S_WRITE: begin
        w_state_nxt = S_FETCH;
        w_k         = '0;
        w_rd        = 1'b1;
        if (r_j != c_JLAST) begin
          w_j = r_j + c_JW'(1);
        end else if (r_i != c_ILAST) begin
          w_j = '0;
          w_i = r_i + c_IW'(1);
        end else begin
          w_state_nxt = S_DONE;
          w_busy      = 1'b0;
          w_done      = 1'b1;
          w_rd        = 1'b0;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if (w_rd) begin
      w_aaddr = f_aaddr(w_i, w_k);
      w_baddr = f_baddr(w_k, w_j);
    end
    if (w_we) begin
      w_caddr = f_caddr(r_i, r_j);
    end
  end

  logic [c_PW-1:0]         w_prod;
  logic [C_DATA_WIDTH-1:0] w_prod_ext;
  logic [C_DATA_WIDTH-1:0] w_acc_nxt;
  logic                    r_vld;
  logic                    r_first;
  logic [C_DATA_WIDTH-1:0] r_acc;
  logic [C_DATA_WIDTH-1:0] r_cdata;

  // Low c_PW bits of a product of extended operands equal the exact product.
  generate
    if (SIGNED != 0) begin : g_signed
      logic [c_PW-1:0] w_a_ext;
      logic [c_PW-1:0] w_b_ext;
      assign w_a_ext    = {{B_DATA_WIDTH{A_data[A_DATA_WIDTH-1]}}, A_data};
      assign w_b_ext    = {{A_DATA_WIDTH{B_data[B_DATA_WIDTH-1]}}, B_data};
      assign w_prod     = w_a_ext * w_b_ext;
      assign w_prod_ext = C_DATA_WIDTH'($signed(w_prod));
    end else begin : g_unsigned
      assign w_prod     = c_PW'(A_data) * c_PW'(B_data);
      assign w_prod_ext = C_DATA_WIDTH'(w_prod);
    end
  endgenerate

  assign w_acc_nxt = r_first ? w_prod_ext : (r_acc + w_prod_ext);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_vld   <= 1'b0;
      r_first <= 1'b0;
      r_acc   <= '0;
      r_cdata <= '0;
    end else begin
      r_vld   <= r_rd;
      r_first <= r_rd && (r_k == '0);
      if (r_vld) begin
        r_acc <= w_acc_nxt;
      end
      if (r_state == S_DRAIN) begin
        r_cdata <= w_acc_nxt;
      end
    end
  end

  assign Busy   = r_busy;
  assign Done   = r_done;
  assign A_re   = r_rd;
  assign B_re   = r_rd;
  assign C_we   = r_we;
  assign A_addr = r_aaddr;
  assign B_addr = r_baddr;
  assign C_addr = r_caddr;
  assign C_data = r_cdata;

endmodule
`default_nettype wire

// File: tb/tb_matrix_mult_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_matrix_mult_engine
// Description : Two engine configurations checked against a phase-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_mult_engine;

  localparam int N0 = 2 * 2 * (2 + 2);
  localparam int N1 = 2 * 2 * (3 + 2);

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  logic Start = 1'b0;
  logic clr   = 1'b0;

  logic        busy0, done0, are0, bre0, cwe0;
  logic [1:0]  aaddr0, baddr0, caddr0;
  logic [7:0]  adata0, bdata0;
  logic [16:0] cdata0;

  logic        busy1, done1, are1, bre1, cwe1;
  logic [2:0]  aaddr1, baddr1;
  logic [1:0]  caddr1;
  logic [7:0]  adata1, bdata1;
  logic [17:0] cdata1;

  logic [7:0]  ma0 [4];
  logic [7:0]  mb0 [4];
  logic [7:0]  ma1 [8];
  logic [7:0]  mb1 [8];
  logic [16:0] mc0 [4];
  logic [17:0] mc1 [4];
  int          dcnt0, dcnt1;

  int checks = 0;
  int errors = 0;
  int ph0 = 0;
  int ph1 = 0;

  always #5 Clock = ~Clock;

  matrix_mult_engine u0 (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Busy(busy0), .Done(done0),
    .A_re(are0), .A_addr(aaddr0), .A_data(adata0),
    .B_re(bre0), .B_addr(baddr0), .B_data(bdata0),
    .C_we(cwe0), .C_addr(caddr0), .C_data(cdata0)
  );

  matrix_mult_engine #(.AROW(2), .ACOL(3), .BCOL(2), .SIGNED(1)) u1 (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Busy(busy1), .Done(done1),
    .A_re(are1), .A_addr(aaddr1), .A_data(adata1),
    .B_re(bre1), .B_addr(baddr1), .B_data(bdata1),
    .C_we(cwe1), .C_addr(caddr1), .C_data(cdata1)
  );

  // Single-cycle-read memories and C capture
  always @(posedge Clock) begin
    if (are0) adata0 <= ma0[aaddr0];
    if (bre0) bdata0 <= mb0[baddr0];
    if (are1) adata1 <= ma1[aaddr1];
    if (bre1) bdata1 <= mb1[baddr1];
    if (clr) begin
      for (int x = 0; x < 4; x++) begin
        mc0[x] <= '1;
        mc1[x] <= '1;
      end
      dcnt0 <= 0;
      dcnt1 <= 0;
    end else begin
      if (cwe0) mc0[caddr0] <= cdata0;
      if (cwe1) mc1[caddr1] <= cdata1;
      if (done0) dcnt0 <= dcnt0 + 1;
      if (done1) dcnt1 <= dcnt1 + 1;
    end
  end

  // Model: phase 0 = idle, 1..N = busy cycles, N+1 = done cycle
  always @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      ph0 <= 0;
      ph1 <= 0;
    end else begin
      ph0 <= (ph0 == 0) ? (Start ? 1 : 0) : ((ph0 == N0 + 1) ? 0 : ph0 + 1);
      ph1 <= (ph1 == 0) ? (Start ? 1 : 0) : ((ph1 == N1 + 1) ? 0 : ph1 + 1);
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint expc(input int id, input int e);
    longint s;
    s = 0;
    if (id == 0) begin
      for (int k = 0; k < 2; k++)
        s += longint'(ma0[(e / 2) * 2 + k]) * longint'(mb0[k * 2 + e % 2]);
      s = s & longint'(17'h1FFFF);
    end else begin
      for (int k = 0; k < 3; k++)
        s += longint'($signed(ma1[(e / 2) * 3 + k])) * longint'($signed(mb1[k * 2 + e % 2]));
      s = s & longint'(18'h3FFFF);
    end
    return s;
  endfunction

  task automatic check_dut(input int id, input int ph, input int ka, input int nb, input int nr,
                           input logic busy, input logic done, input logic are, input logic bre,
                           input logic cwe, input longint aa, input longint ba,
                           input longint ca, input longint cd);
    int  len, n, e, p;
    bit  active, fetch, wr;
    len    = ka + 2;
    n      = nr * nb * len;
    e      = (ph - 1) / len;
    p      = (ph - 1) % len;
    active = (ph >= 1) && (ph <= n);
    fetch  = active && (p < ka);
    wr     = active && (p == ka + 1);
    chk($sformatf("dut%0d busy ph%0d", id, ph), busy, active);
    chk($sformatf("dut%0d done ph%0d", id, ph), done, ph == n + 1);
    chk($sformatf("dut%0d a_re ph%0d", id, ph), are, fetch);
    chk($sformatf("dut%0d b_re ph%0d", id, ph), bre, fetch);
    chk($sformatf("dut%0d c_we ph%0d", id, ph), cwe, wr);
    if (fetch) begin
      chk($sformatf("dut%0d a_addr ph%0d", id, ph), aa, (e / nb) * ka + p);
      chk($sformatf("dut%0d b_addr ph%0d", id, ph), ba, p * nb + e % nb);
    end
    if (wr) begin
      chk($sformatf("dut%0d c_addr ph%0d", id, ph), ca, e);
      chk($sformatf("dut%0d c_data e%0d", id, e), cd, expc(id, e));
    end
  endtask

  always @(negedge Clock) begin
    if (!Reset) begin
      check_dut(0, ph0, 2, 2, 2, busy0, done0, are0, bre0, cwe0, aaddr0, baddr0, caddr0, cdata0);
      check_dut(1, ph1, 3, 2, 2, busy1, done1, are1, bre1, cwe1, aaddr1, baddr1, caddr1, cdata1);
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, " busy0"}, busy0, 0);  chk({tag, " busy1"}, busy1, 0);
    chk({tag, " done0"}, done0, 0);  chk({tag, " done1"}, done1, 0);
    chk({tag, " are0"}, are0, 0);    chk({tag, " are1"}, are1, 0);
    chk({tag, " bre0"}, bre0, 0);    chk({tag, " bre1"}, bre1, 0);
    chk({tag, " cwe0"}, cwe0, 0);    chk({tag, " cwe1"}, cwe1, 0);
    chk({tag, " aaddr0"}, aaddr0, 0); chk({tag, " aaddr1"}, aaddr1, 0);
    chk({tag, " baddr0"}, baddr0, 0); chk({tag, " baddr1"}, baddr1, 0);
    chk({tag, " caddr0"}, caddr0, 0); chk({tag, " caddr1"}, caddr1, 0);
    chk({tag, " cdata0"}, cdata0, 0); chk({tag, " cdata1"}, cdata1, 0);
  endtask

  task automatic wait_idle(input bit pulses);
    int n;
    n = 0;
    while ((ph0 != 0 || ph1 != 0) && n < 300) begin
      @(negedge Clock);
      Start = pulses && (ph0 >= 1) && (ph0 <= N0 + 1) &&
              ((ph0 == N0 + 1) || ($urandom_range(0, 3) == 0));
      n++;
    end
    Start = 1'b0;
    chk("run completes", (ph0 == 0 && ph1 == 0), 1);
  endtask

  task automatic launch();
    @(negedge Clock);
    clr = 1'b1;
    @(negedge Clock);
    clr   = 1'b0;
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
  endtask

  task automatic run(input bit pulses);
    launch();
    wait_idle(pulses);
    @(negedge Clock);
    chk("done count0", dcnt0, 1);
    chk("done count1", dcnt1, 1);
  endtask

  task automatic load_basic();
    for (int x = 0; x < 4; x++) begin
      ma0[x] = 8'(x + 1);
      mb0[x] = 8'(x + 5);
    end
    for (int x = 0; x < 6; x++) begin
      ma1[x] = 8'(x + 1);
      mb1[x] = 8'(x + 7);
    end
  endtask

  task automatic check_basic(input string tag);
    chk({tag, " c0[0]"}, mc0[0], 19);
    chk({tag, " c0[1]"}, mc0[1], 22);
    chk({tag, " c0[2]"}, mc0[2], 43);
    chk({tag, " c0[3]"}, mc0[3], 50);
    chk({tag, " c1[0]"}, mc1[0], 58);
    chk({tag, " c1[1]"}, mc1[1], 64);
    chk({tag, " c1[2]"}, mc1[2], 139);
    chk({tag, " c1[3]"}, mc1[3], 154);
  endtask

  initial begin
    for (int x = 0; x < 8; x++) begin
      ma1[x] = '0;
      mb1[x] = '0;
    end
    @(posedge Clock);
    #1;
    check_zero("reset");
    @(negedge Clock);
    Reset = 1'b0;
    repeat (2) @(negedge Clock);

    load_basic();
    run(0);
    check_basic("basic");

    // Unsigned full-scale and signed extremes; Start pulses while busy/done
    for (int x = 0; x < 4; x++) begin
      ma0[x] = 8'hFF;
      mb0[x] = 8'hFF;
    end
    ma1[0] = 8'h80; ma1[1] = 8'h80; ma1[2] = 8'h80;
    ma1[3] = 8'hFF; ma1[4] = 8'h02; ma1[5] = 8'h00;
    mb1[0] = 8'h80; mb1[1] = 8'h03; mb1[2] = 8'h80;
    mb1[3] = 8'hFC; mb1[4] = 8'h80; mb1[5] = 8'h00;
    run(1);
    for (int x = 0; x < 4; x++) chk($sformatf("max c0[%0d]", x), mc0[x], 130050);
    chk("neg c1[0]", mc1[0], 49152);
    chk("neg c1[1]", mc1[1], 128);
    chk("neg c1[2]", mc1[2], 262016);
    chk("neg c1[3]", mc1[3], 262133);

    // Reset while fetching the third element
    load_basic();
    launch();
    while (ph0 != 9) @(negedge Clock);
    #2;
    Reset = 1'b1;
    #1;
    check_zero("midreset");
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    repeat (6) @(negedge Clock);
    chk("midreset no done0", dcnt0, 0);
    chk("midreset c0[2] unwritten", mc0[2], 17'h1FFFF);
    run(0);
    check_basic("after reset");

    for (int r = 0; r < 6; r++) begin
      for (int x = 0; x < 4; x++) begin
        ma0[x] = 8'($urandom);
        mb0[x] = 8'($urandom);
      end
      for (int x = 0; x < 6; x++) begin
        ma1[x] = 8'($urandom);
        mb1[x] = 8'($urandom);
      end
      run(r[0]);
    end

    // Start held high: back-to-back runs
    launch();
    Start = 1'b1;
    repeat (60) @(negedge Clock);
    Start = 1'b0;
    wait_idle(0);
    chk("held start repeats", dcnt0 >= 3, 1);

    repeat (3) @(negedge Clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
